// File: rtl/trigger_sequencer_pkg.sv
// Shared encodings for the trigger sequencer: FSM states, acquisition modes, slopes.
package trigger_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PREFILL  = 3'd1,
        ARMED    = 3'd2,
        POSTFILL = 3'd3,
        READY    = 3'd4
    } seq_state_e;

    localparam logic [1:0] MODE_AUTO   = 2'd0;
    localparam logic [1:0] MODE_NORMAL = 2'd1;
    localparam logic [1:0] MODE_SINGLE = 2'd2;
    localparam logic [1:0] MODE_STOP   = 2'd3;

    localparam logic SLOPE_RISING  = 1'b0;
    localparam logic SLOPE_FALLING = 1'b1;

endpackage

// File: rtl/trigger_sequencer_detect.sv
// Level/slope crossing detector with holdoff; emits the raw crossing and the registered isTrigger strobe.
module trigger_detect
    import trigger_sequencer_pkg::*;
#(
    parameter int DATA_BITS       = 12,
    parameter int HOLDOFF_SAMPLES = 16
) (
    input  logic                        clock,
    input  logic                        resetN,
    input  logic                        dataReady,
    input  logic signed [DATA_BITS-1:0] dataIn,
    input  logic signed [DATA_BITS-1:0] triggerLevel,
    input  logic                        triggerSlope,
    input  logic                        enable,
    output logic                        crossing,
    output logic                        holdoffOk,
    output logic                        isTrigger
);

    localparam int HW = $clog2(HOLDOFF_SAMPLES + 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLDOFF_SAMPLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDOFF_SAMPLES - 1);

    logic signed [DATA_BITS-1:0] prevSample;
    logic                        prevValid;
    logic [HW-1:0]               holdCount;
    logic                        holdActive;
    logic                        fire;

    always_comb begin
        crossing = 1'b0;
        if (dataReady && prevValid) begin
            if (triggerSlope == SLOPE_RISING)
                crossing = (prevSample < triggerLevel) && (dataIn >= triggerLevel);
            else
                crossing = (prevSample > triggerLevel) && (dataIn <= triggerLevel);
        end
    end

    // holdCount counts samples after the last strobe; the current sample makes it +1.
    // Until the first strobe there is nothing to hold off from.
    assign holdoffOk = !holdActive || (holdCount >= HOLD_LAST);
    assign fire      = crossing && holdoffOk && enable;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            prevSample <= '0;
            prevValid  <= 1'b0;
            holdCount  <= '0;
            holdActive <= 1'b0;
            isTrigger  <= 1'b0;
        end else begin
            isTrigger <= fire;
            if (dataReady) begin
                prevSample <= dataIn;
                prevValid  <= 1'b1;
                if (fire) begin
                    holdActive <= 1'b1;
                    holdCount  <= '0;
                end else if (holdCount != HOLD_MAX) begin
                    holdCount <= holdCount + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/trigger_sequencer.sv
// Acquisition sequencer: drives the circular capture RAM with a pre/post-trigger split
// and hands each completed frame to the display via captureReady/displayDone.
module trigger_sequencer
    import trigger_sequencer_pkg::*;
#(
    parameter int DATA_BITS            = 12,
    parameter int ADDR_BITS            = 10,
    parameter int AUTO_TIMEOUT_SAMPLES = 500000,
    parameter int HOLDOFF_SAMPLES      = 16
) (
    input  logic                        clock,
    input  logic                        resetN,
    input  logic                        dataReady,
    input  logic signed [DATA_BITS-1:0] dataIn,
    input  logic signed [DATA_BITS-1:0] triggerLevel,
    input  logic                        triggerSlope,
    input  logic [1:0]                  triggerMode,
    input  logic [ADDR_BITS-1:0]        preTriggerCount,
    input  logic                        arm,
    input  logic                        displayDone,
    output logic                        isTrigger,
    output logic                        bufWriteEnable,
    output logic [ADDR_BITS-1:0]        bufWriteAddr,
    output logic [DATA_BITS-1:0]        bufWriteData,
    output logic [ADDR_BITS-1:0]        triggerAddr,
    output logic                        captureReady,
    output logic                        autoTriggered,
    output logic [2:0]                  seqState
);

    localparam int TW = $clog2(AUTO_TIMEOUT_SAMPLES + 1);
    localparam logic [TW-1:0]        TIMEOUT_LAST = TW'(AUTO_TIMEOUT_SAMPLES - 1);
    localparam logic [TW-1:0]        TIMEOUT_MAX  = TW'(AUTO_TIMEOUT_SAMPLES);
    localparam logic [ADDR_BITS-1:0] LAST_ADDR    = '1;

    seq_state_e state, nextState;

    logic [ADDR_BITS-1:0] writePtr, fillCount, preLatch, postLatch;
    logic [TW-1:0]        armedCount;
    logic crossing, holdoffOk, detectEnable;
    logic captureHit, timeoutHit, fillDone, postDone;
    logic sampleWrite, holdReady;

    trigger_detect #(
        .DATA_BITS      (DATA_BITS),
        .HOLDOFF_SAMPLES(HOLDOFF_SAMPLES)
    ) u_detect (
        .clock       (clock),
        .resetN      (resetN),
        .dataReady   (dataReady),
        .dataIn      (dataIn),
        .triggerLevel(triggerLevel),
        .triggerSlope(triggerSlope),
        .enable      (detectEnable),
        .crossing    (crossing),
        .holdoffOk   (holdoffOk),
        .isTrigger   (isTrigger)
    );

    // A zero pre/post length completes without waiting for a sample.
    assign captureHit = crossing && holdoffOk;
    assign timeoutHit = dataReady && (triggerMode == MODE_AUTO) && (armedCount >= TIMEOUT_LAST);
    assign fillDone   = (preLatch == '0)  || (dataReady && (fillCount == preLatch - 1'b1));
    assign postDone   = (postLatch == '0) || (dataReady && (fillCount == postLatch - 1'b1));

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) state <= IDLE;
        else         state <= nextState;
    end

    always_comb begin
        nextState = state;
        if (triggerMode == MODE_STOP) begin
            nextState = IDLE;
        end else begin
            case (state)
                IDLE:     if (triggerMode != MODE_SINGLE || arm) nextState = PREFILL;
                PREFILL:  if (fillDone) nextState = ARMED;
                ARMED:    if (captureHit || timeoutHit) nextState = POSTFILL;
                POSTFILL: if (postDone) nextState = READY;
                READY:    if (displayDone)
                              nextState = (triggerMode == MODE_SINGLE) ? IDLE : PREFILL;
                default:  nextState = IDLE;
            endcase
        end
    end

    always_comb begin
        seqState     = state;
        detectEnable = (state != IDLE);
        sampleWrite  = dataReady && (triggerMode != MODE_STOP) &&
                       ((state == PREFILL) || (state == ARMED) || (state == POSTFILL));
        holdReady    = (state == READY) && (nextState == READY);
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            bufWriteEnable <= 1'b0;
            bufWriteAddr   <= '0;
            bufWriteData   <= '0;
            writePtr       <= '0;
            triggerAddr    <= '0;
            captureReady   <= 1'b0;
            autoTriggered  <= 1'b0;
            preLatch       <= '0;
            postLatch      <= '0;
            fillCount      <= '0;
            armedCount     <= '0;
        end else begin
            bufWriteEnable <= sampleWrite;
            if (sampleWrite) begin
                bufWriteAddr <= writePtr;
                bufWriteData <= dataIn;
                writePtr     <= writePtr + 1'b1;
            end
            // Registered one past READY entry so it follows the final write.
            captureReady <= holdReady;

            // preTriggerCount is ADDR_BITS wide, so it can never exceed DEPTH-1.
            if (state != PREFILL && nextState == PREFILL) begin
                preLatch  <= preTriggerCount;
                fillCount <= '0;
            end else if (state == ARMED && nextState == POSTFILL) begin
                triggerAddr   <= writePtr;
                autoTriggered <= !captureHit;
                postLatch     <= LAST_ADDR - preLatch;
                fillCount     <= '0;
            end else if (dataReady && (state == PREFILL || state == POSTFILL)) begin
                fillCount <= fillCount + 1'b1;
            end

            if (state != ARMED)
                armedCount <= '0;
            else if (dataReady && armedCount != TIMEOUT_MAX)
                armedCount <= armedCount + 1'b1;
        end
    end

endmodule

// File: tb/tb_trigger_sequencer.sv
// Scoreboard bench for trigger_sequencer: write stream and isTrigger strobes checked against expected queues.
module tb_trigger_sequencer;
    import trigger_sequencer_pkg::*;

    localparam int DW = 12;
    localparam int AW = 4;
    localparam int W  = AW + DW;

    logic                 clock = 1'b0;
    logic                 resetN;
    logic                 dataReady;
    logic signed [DW-1:0] dataIn;
    logic signed [DW-1:0] triggerLevel;
    logic                 triggerSlope;
    logic [1:0]           triggerMode;
    logic [AW-1:0]        preTriggerCount;
    logic                 arm;
    logic                 displayDone;
    logic                 isTrigger;
    logic                 bufWriteEnable;
    logic [AW-1:0]        bufWriteAddr;
    logic [DW-1:0]        bufWriteData;
    logic [AW-1:0]        triggerAddr;
    logic                 captureReady;
    logic                 autoTriggered;
    logic [2:0]           seqState;

    trigger_sequencer #(
        .DATA_BITS           (DW),
        .ADDR_BITS           (AW),
        .AUTO_TIMEOUT_SAMPLES(20),
        .HOLDOFF_SAMPLES     (16)
    ) dut (
        .clock          (clock),
        .resetN         (resetN),
        .dataReady      (dataReady),
        .dataIn         (dataIn),
        .triggerLevel   (triggerLevel),
        .triggerSlope   (triggerSlope),
        .triggerMode    (triggerMode),
        .preTriggerCount(preTriggerCount),
        .arm            (arm),
        .displayDone    (displayDone),
        .isTrigger      (isTrigger),
        .bufWriteEnable (bufWriteEnable),
        .bufWriteAddr   (bufWriteAddr),
        .bufWriteData   (bufWriteData),
        .triggerAddr    (triggerAddr),
        .captureReady   (captureReady),
        .autoTriggered  (autoTriggered),
        .seqState       (seqState)
    );

    // clock / cycle counter
    always #5 clock = ~clock;
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // scoreboard state
    logic [W-1:0]  exp_q[$];
    logic [31:0]   trig_q[$];
    logic [AW-1:0] exp_ptr;
    bit            check_writes;
    bit            ready_prev;
    int            last_wr_cyc;
    int            ready_rise_cyc;
    int            n_checks = 0;
    int            n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_isTrigger"},    32'(isTrigger),      0);
        check_eq({tag, "_wrEnable"},     32'(bufWriteEnable), 0);
        check_eq({tag, "_wrAddr"},       32'(bufWriteAddr),   0);
        check_eq({tag, "_wrData"},       32'(bufWriteData),   0);
        check_eq({tag, "_triggerAddr"},  32'(triggerAddr),    0);
        check_eq({tag, "_captureReady"}, 32'(captureReady),   0);
        check_eq({tag, "_autoTrig"},     32'(autoTriggered),  0);
        check_eq({tag, "_seqState"},     32'(seqState),       0);
    endtask

    // monitor: pops expectations as the DUT produces writes and strobes
    always @(negedge clock) begin
        if (resetN) begin
            if (bufWriteEnable) begin
                last_wr_cyc = cyc;
                if (check_writes) begin
                    if (exp_q.size() == 0) check_eq("wr_unexpected", 32'(bufWriteAddr), 32'hFFFF);
                    else check_eq("wr_addr_data", 32'({bufWriteAddr, bufWriteData}), 32'(exp_q.pop_front()));
                end
            end
            if (isTrigger) begin
                if (trig_q.size() == 0) check_eq("trig_unexpected", 32'(cyc), 32'hFFFF_FFFF);
                else check_eq("trig_cycle", 32'(cyc), trig_q.pop_front());
            end
            if (captureReady && !ready_prev) ready_rise_cyc = cyc;
            ready_prev = captureReady;
        end
    end

    task automatic clear_sb();
        exp_q.delete();
        trig_q.delete();
        exp_ptr        = '0;
        ready_prev     = 1'b0;
        last_wr_cyc    = -1;
        ready_rise_cyc = -1;
    endtask

    task automatic apply_reset(input logic [1:0] mode, input logic [AW-1:0] pre);
        @(negedge clock);
        resetN = 1'b0; dataReady = 1'b0; arm = 1'b0; displayDone = 1'b0;
        triggerMode = mode; preTriggerCount = pre;
        clear_sb();
        repeat (2) @(negedge clock);
        resetN = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    // driver: one sample with a random idle gap, expectations pushed as it is driven
    task automatic drive_sample(input logic signed [DW-1:0] v, input bit exp_wr, input bit exp_trig);
        repeat ($urandom_range(0, 2)) @(negedge clock);
        @(negedge clock);
        dataIn = v; dataReady = 1'b1;
        if (exp_wr) begin
            exp_q.push_back({exp_ptr, v});
            exp_ptr = exp_ptr + 1'b1;
        end
        if (exp_trig) trig_q.push_back(32'(cyc + 1));
        @(negedge clock);
        dataReady = 1'b0;
    endtask

    task automatic pulse_display_done();
        @(negedge clock); displayDone = 1'b1;
        @(negedge clock); displayDone = 1'b0;
    endtask

    task automatic check_drained(input string tag);
        repeat (2) @(negedge clock);
        check_eq({tag, "_wr_q_left"},   32'(exp_q.size()),  0);
        check_eq({tag, "_trig_q_left"}, 32'(trig_q.size()), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetN = 1'b0; dataReady = 1'b0; dataIn = '0; arm = 1'b0; displayDone = 1'b0;
        triggerLevel = '0; triggerSlope = SLOPE_RISING; triggerMode = MODE_NORMAL;
        preTriggerCount = 4'd4; check_writes = 1'b1;
        clear_sb();

        // reset state
        repeat (3) @(negedge clock);
        check_all_zero("reset");

        // normal mode ramp, crossing on sample 12, pre=4 -> post=11, 24 writes
        apply_reset(MODE_NORMAL, 4'd4);
        for (int k = 0; k < 24; k++) drive_sample(12'(k - 12), 1'b1, k == 12);
        drive_sample(12'sd12, 1'b0, 1'b0);
        drive_sample(12'sd13, 1'b0, 1'b0);
        check_drained("normal");
        check_eq("normal_triggerAddr", 32'(triggerAddr), 12);
        check_eq("normal_autoTrig", 32'(autoTriggered), 0);
        check_eq("normal_captureReady", 32'(captureReady), 1);
        check_eq("normal_seqState", 32'(seqState), 32'(READY));
        check_eq("normal_ready_latency", 32'(ready_rise_cyc - last_wr_cyc), 1);
        pulse_display_done();
        check_eq("normal_done_state", 32'(seqState), 32'(PREFILL));
        check_eq("normal_done_ready", 32'(captureReady), 0);

        // holdoff: period-8 square wave, strobe on every second rising edge
        check_writes = 1'b0;
        apply_reset(MODE_NORMAL, 4'd4);
        for (int k = 0; k < 56; k++)
            drive_sample(((k / 4) % 2) != 0 ? 12'sd100 : -12'sd100, 1'b0,
                         (k == 4) || (k == 20) || (k == 36) || (k == 52));
        check_drained("holdoff");
        check_writes = 1'b1;

        // auto mode: forced capture on the 20th ARMED sample (sample 23)
        triggerLevel = 12'sd500;
        apply_reset(MODE_AUTO, 4'd4);
        for (int k = 0; k < 35; k++) drive_sample(12'sd100, 1'b1, 1'b0);
        drive_sample(12'sd100, 1'b0, 1'b0);
        check_drained("auto");
        check_eq("auto_triggerAddr", 32'(triggerAddr), 7);
        check_eq("auto_autoTrig", 32'(autoTriggered), 1);
        check_eq("auto_captureReady", 32'(captureReady), 1);
        triggerLevel = '0;

        // single mode: nothing until arm; after the frame, back to IDLE
        apply_reset(MODE_SINGLE, 4'd2);
        drive_sample(-12'sd10, 1'b0, 1'b0);
        drive_sample(12'sd10, 1'b0, 1'b0);
        drive_sample(-12'sd10, 1'b0, 1'b0);
        check_drained("single_idle");
        check_eq("single_idle_state", 32'(seqState), 32'(IDLE));
        @(negedge clock); arm = 1'b1;
        @(negedge clock); arm = 1'b0;
        drive_sample(-12'sd10, 1'b1, 1'b0);
        drive_sample(-12'sd10, 1'b1, 1'b0);
        drive_sample(-12'sd5, 1'b1, 1'b0);
        drive_sample(12'sd5, 1'b1, 1'b1);
        for (int k = 0; k < 13; k++) drive_sample(12'sd5, 1'b1, 1'b0);
        check_drained("single_frame");
        check_eq("single_triggerAddr", 32'(triggerAddr), 3);
        check_eq("single_captureReady", 32'(captureReady), 1);
        pulse_display_done();
        check_eq("single_done_state", 32'(seqState), 32'(IDLE));
        drive_sample(-12'sd10, 1'b0, 1'b0);
        drive_sample(12'sd10, 1'b0, 1'b0);
        check_drained("single_rearm");
        check_eq("single_rearm_state", 32'(seqState), 32'(IDLE));
        check_eq("single_rearm_ready", 32'(captureReady), 0);

        // stop mid-POSTFILL, applied together with a sample
        apply_reset(MODE_NORMAL, 4'd4);
        for (int k = 0; k < 16; k++) drive_sample(12'(k - 12), 1'b1, k == 12);
        triggerMode = MODE_STOP;
        drive_sample(12'sd4, 1'b0, 1'b0);
        drive_sample(12'sd5, 1'b0, 1'b0);
        check_drained("stop");
        check_eq("stop_state", 32'(seqState), 32'(IDLE));
        check_eq("stop_ready", 32'(captureReady), 0);
        check_eq("stop_wrEnable", 32'(bufWriteEnable), 0);

        // asynchronous reset mid-ARMED, then first sample must not trigger
        apply_reset(MODE_NORMAL, 4'd4);
        for (int k = 0; k < 6; k++) drive_sample(-12'sd50, 1'b1, 1'b0);
        check_drained("async_pre");
        @(negedge clock); dataIn = -12'sd50; dataReady = 1'b1;
        @(posedge clock); #2;
        resetN = 1'b0; dataReady = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(negedge clock); clear_sb();
        @(negedge clock); resetN = 1'b1;
        repeat (2) @(negedge clock);
        drive_sample(12'sd50, 1'b1, 1'b0);
        drive_sample(12'sd60, 1'b1, 1'b0);
        drive_sample(-12'sd50, 1'b1, 1'b0);
        drive_sample(12'sd50, 1'b1, 1'b1);
        check_drained("async_post");
        check_eq("async_post_state", 32'(seqState), 32'(ARMED));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
